fp_row_acc_issue: RTL and testbench

- Upstream sequencer for the registered floating-point add stage (operand A on `value`, operand B on `row`, sum on `data`, 2-clock latency).
- Accepts a stream of IEEE-754 single-precision elements grouped into rows, where `in_last` marks the final element of a row.
- Keeps the row's running partial sum and issues one add per element to the adder stage, stalling for the adder latency.
- Emits one completed row sum per row on a valid/ready output.

---
 rtl/fp_row_acc_issue_if.sv | 32 +++
 rtl/fp_row_acc_issue.sv | 159 +++++++++++++++
 tb/tb_fp_row_acc_issue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_row_acc_issue_if.sv
// fp_row_acc_issue_if
//   Bundles the three streams around the row accumulator:
//     - element input  : in_valid / in_ready / in_value / in_last
//     - adder stage    : add_a / add_b (operands out), add_sum (result in)
//     - row sum output : out_valid / out_ready / out_sum / out_count
//   slave  : view taken by fp_row_acc_issue
//   master : view taken by the environment (source, adder, consumer)
interface fp_row_acc_issue_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_value;
    logic             in_last;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_value, in_last, add_sum, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_count
    );

    modport master (
        output in_valid, in_value, in_last, add_sum, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/fp_row_acc_issue.sv
// fp_row_acc_issue
//   Sequences a stream of IEEE-754 single elements, grouped into rows by
//   in_last, through an external registered float adder. The first element of
//   a row seeds the accumulator; each later element is issued as
//   add_a = element, add_b = running sum, and the block stalls until the
//   adder result is captured. One row sum (plus element count) is emitted per
//   row on a valid/ready output. No float arithmetic is done here.
//
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus       : fp_row_acc_issue_if.slave (input stream, adder, output)
//
//   Optional feature macro: ROW_ACC_SKIP_ZERO_EN
//     When defined, a +/-0.0 element arriving with a row open is counted but
//     not issued to the adder (accumulator unchanged, no stall).
module fp_row_acc_issue #(
    parameter int ADD_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_row_acc_issue_if.slave   bus
);
    localparam int LAT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADD_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_pend_q, last_pend_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [31:0]      add_a_q, add_a_d;
    logic [31:0]      add_b_q, add_b_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             skip_zero;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_OPEN);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    // Counter saturates; elements past the limit still accumulate.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef ROW_ACC_SKIP_ZERO_EN
    assign skip_zero = (bus.in_value[30:0] == 31'd0);
`else
    assign skip_zero = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        last_pend_d = last_pend_q;
        lat_cnt_d   = lat_cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;

        case (state_q)
            S_IDLE: begin
                // First element seeds the sum directly; nothing to add yet.
                if (in_fire) begin
                    acc_d   = bus.in_value;
                    cnt_d   = CNT_W'(1);
                    state_d = bus.in_last ? S_EMIT : S_OPEN;
                end
            end
            S_OPEN: begin
                if (in_fire) begin
                    cnt_d = cnt_inc;
                    if (skip_zero) begin
                        state_d = bus.in_last ? S_EMIT : S_OPEN;
                    end else begin
                        add_a_d     = bus.in_value;
                        add_b_d     = acc_q;
                        lat_cnt_d   = LAT_INIT;
                        last_pend_d = bus.in_last;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // lat_cnt reaching zero marks the cycle add_sum is valid.
                if (lat_cnt_q == '0) begin
                    acc_d   = bus.add_sum;
                    state_d = last_pend_q ? S_EMIT : S_OPEN;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_EMIT: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded on EMIT entry and then held, so the
        // presented sum/count cannot move while the consumer stalls.
        if ((state_d == S_EMIT) && (state_q != S_EMIT)) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_d;
            out_count_d = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
            lat_cnt_q   <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            lat_cnt_q   <= lat_cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_fp_row_acc_issue.sv
// tb_fp_row_acc_issue
//   Randomized + directed stimulus with a scoreboard. Each row pushes its
//   expected sum, element count and number of adder-stall cycles; a negedge
//   monitor pops and compares on every output handshake. A two-stage
//   registered float adder model sits on add_a/add_b/add_sum. The counter is
//   built narrow (CNT_W=3) so saturation is reachable in short rows.
module tb_fp_row_acc_issue;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_row_acc_issue_if #(.CNT_W(CW)) ifc ();

    fp_row_acc_issue #(.ADD_LAT(2), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- float helpers (normal numbers and zeros only) ----
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // ---- adder stage model: operands registered twice -> add_sum ----
    logic [31:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        s1 <= r2f(f2r(ifc.add_a) + f2r(ifc.add_b));
        s2 <= s1;
    end
    assign ifc.add_sum = s2;

    // ---- scoreboard ----
    typedef struct {
        logic [31:0] sum;
        int          cnt;
        int          stalls;
    } exp_t;
    exp_t sb[$];
    logic [31:0] row_vals[$];

    int  hold_cnt  = 0;
    bit  rand_mode = 1'b0;
    int  stalls    = 0;
    bit  prev_hold = 1'b0;
    logic [31:0]   prev_sum;
    logic [CW-1:0] prev_cnt;

    always @(negedge clk) begin
        if (hold_cnt > 0) begin
            ifc.out_ready = 1'b0;
            if (ifc.out_valid) hold_cnt--;
        end else begin
            ifc.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rst) begin
            stalls    = 0;
            prev_hold = 1'b0;
        end else begin
            if (ifc.out_valid) begin
                chk("in_ready_low_in_emit", 32'(ifc.in_ready), 32'd0);
                if (prev_hold) begin
                    chk("held_sum", ifc.out_sum, prev_sum);
                    chk("held_count", 32'(ifc.out_count), 32'(prev_cnt));
                end
                if (ifc.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_emit", 32'(ifc.out_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("row_sum", ifc.out_sum, e.sum);
                        chk("row_count", 32'(ifc.out_count), 32'(e.cnt));
                        chk("row_stalls", 32'(stalls), 32'(e.stalls));
                    end
                    stalls = 0;
                end
            end else if (!ifc.in_ready) begin
                stalls++;
            end
            prev_hold = ifc.out_valid & ~ifc.out_ready;
            prev_sum  = ifc.out_sum;
            prev_cnt  = ifc.out_count;
        end
    end

    // ---- stimulus helpers (called at a negedge, return at a negedge) ----
    task automatic send(input logic [31:0] v, input logic l);
        int b = 0;
        ifc.in_valid = 1'b1;
        ifc.in_value = v;
        ifc.in_last  = l;
        while (!ifc.in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    // Expected sum given explicitly; count and stall cycles derived from the
    // element list: every non-first element costs ADD_LAT+1 stalled cycles
    // unless zero-skipping applies to it.
    task automatic send_row(input logic [31:0] exp_sum);
        exp_t e;
        int   issues = 0;
        for (int i = 1; i < row_vals.size(); i++) begin
`ifdef ROW_ACC_SKIP_ZERO_EN
            if (row_vals[i][30:0] != 31'd0) issues++;
`else
            issues++;
`endif
        end
        e.sum    = exp_sum;
        e.cnt    = (row_vals.size() > CMAX) ? CMAX : row_vals.size();
        e.stalls = 3 * issues;
        sb.push_back(e);
        for (int i = 0; i < row_vals.size(); i++)
            send(row_vals[i], i == row_vals.size() - 1);
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (b >= 500) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},  32'(ifc.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, "_add_a"},     ifc.add_a,          32'd0);
        chk({tag, "_add_b"},     ifc.add_b,          32'd0);
        chk({tag, "_out_sum"},   ifc.out_sum,        32'd0);
        chk({tag, "_out_count"}, 32'(ifc.out_count), 32'd0);
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_value = '0;
        ifc.in_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // single-element row: passes through bit-exact, no adder issue
        row_vals = '{32'h40490FDB};
        send_row(32'h40490FDB);
        chk("single_valid_next_cycle", 32'(ifc.out_valid), 32'd1);
        drain();
        chk("single_add_a", ifc.add_a, 32'd0);
        chk("single_add_b", ifc.add_b, 32'd0);

        // 1 + 2 + 3
        row_vals = '{32'h3F800000, 32'h40000000, 32'h40400000};
        send_row(32'h40C00000);
        drain();

        // backpressure: output held for 5 cycles
        hold_cnt = 5;
        row_vals = '{32'h40000000, 32'h40000000};
        send_row(32'h40800000);
        drain();
        chk("bp_back_to_idle", 32'(ifc.in_ready), 32'd1);

        // reset during WAIT drops the partial row
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrow_reset");
        row_vals = '{32'h40400000};
        send_row(32'h40400000);
        drain();

        // zeros of both signs inside a row
        row_vals = '{32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000};
        send_row(32'h40000000);
        drain();

        // back-to-back single-element rows
        row_vals = '{32'h3F800000};
        send_row(32'h3F800000);
        row_vals = '{32'h40000000};
        send_row(32'h40000000);
        drain();

        // counter saturation: nine 1.0 elements
        row_vals = {};
        for (int i = 0; i < 9; i++) row_vals.push_back(32'h3F800000);
        send_row(32'h41100000);
        drain();

        // random rows of small integers and signed zeros, random backpressure
        rand_mode = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int n, sum, k;
            n   = $urandom_range(1, 10);
            sum = 0;
            row_vals = {};
            for (int i = 0; i < n; i++) begin
                if (i != 0 && $urandom_range(0, 3) == 0) begin
                    row_vals.push_back({1'($urandom_range(0, 1)), 31'd0});
                end else begin
                    k = $urandom_range(1, 20);
                    sum += k;
                    row_vals.push_back(r2f(real'(k)));
                end
            end
            send_row(r2f(real'(sum)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
